// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - machine-level CLINT: 64-bit mtime/mtimecmp, msip, prescaled tick
// Bus reads return registered data one cycle after the request; bad offsets pulse bus_err.
module clint_timer #(
  parameter int ADDR_WIDTH = 16,
  parameter int TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mtime_en,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic                  bus_rvalid,
  output logic [31:0]           bus_rdata,
  output logic                  bus_err,
  output logic                  irq_timer,
  output logic                  irq_software
);

  localparam logic [ADDR_WIDTH-1:0] OFF_MSIP     = ADDR_WIDTH'(32'h0000);
  localparam logic [ADDR_WIDTH-1:0] OFF_CMP_LO   = ADDR_WIDTH'(32'h4000);
  localparam logic [ADDR_WIDTH-1:0] OFF_CMP_HI   = ADDR_WIDTH'(32'h4004);
  localparam logic [ADDR_WIDTH-1:0] OFF_MTIME_LO = ADDR_WIDTH'(32'hBFF8);
  localparam logic [ADDR_WIDTH-1:0] OFF_MTIME_HI = ADDR_WIDTH'(32'hBFFC);
  localparam logic [15:0]           PRESC_MAX    = 16'(TICK_DIV - 1);

  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [15:0] presc_q, presc_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        irq_timer_q, irq_timer_d;

  logic tick;
  logic wr, rd;
  logic hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi, mapped;

  // Misaligned offsets never equal a word-aligned register offset, so they fall out as unmapped.
  assign hit_msip    = (bus_addr == OFF_MSIP);
  assign hit_cmp_lo  = (bus_addr == OFF_CMP_LO);
  assign hit_cmp_hi  = (bus_addr == OFF_CMP_HI);
  assign hit_time_lo = (bus_addr == OFF_MTIME_LO);
  assign hit_time_hi = (bus_addr == OFF_MTIME_HI);
  assign mapped      = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi;

  assign wr   = bus_req & bus_we & mapped;
  assign rd   = bus_req & ~bus_we;
  assign tick = mtime_en & (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    if (mtime_en) presc_d = tick ? 16'd0 : 16'(presc_q + 16'd1);

    // A half-write overrides only its half; the other half keeps the incremented value and carry.
    mtime_inc = mtime_q + 64'(tick);
    mtime_d   = mtime_inc;
    if (wr && hit_time_lo) mtime_d[31:0]  = bus_wdata;
    if (wr && hit_time_hi) mtime_d[63:32] = bus_wdata;

    mtimecmp_d = mtimecmp_q;
    if (wr && hit_cmp_lo) mtimecmp_d[31:0]  = bus_wdata;
    if (wr && hit_cmp_hi) mtimecmp_d[63:32] = bus_wdata;

    msip_d = msip_q;
    if (wr && hit_msip) msip_d = bus_wdata[0];

    rdata_d = 32'd0;
    if (rd) begin
      if (hit_msip)    rdata_d = {31'd0, msip_q};
      if (hit_cmp_lo)  rdata_d = mtimecmp_q[31:0];
      if (hit_cmp_hi)  rdata_d = mtimecmp_q[63:32];
      if (hit_time_lo) rdata_d = mtime_q[31:0];
      if (hit_time_hi) rdata_d = mtime_q[63:32];
    end
    rvalid_d    = rd;
    err_d       = bus_req & ~mapped;
    irq_timer_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      presc_q     <= 16'd0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      irq_timer_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      presc_q     <= presc_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      irq_timer_q <= irq_timer_d;
    end
  end

  assign bus_rvalid   = rvalid_q;
  assign bus_rdata    = rdata_q;
  assign bus_err      = err_q;
  assign irq_timer    = irq_timer_q;
  assign irq_software = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - directed self-checking bench for clint_timer
// Two instances share clk/rst: one with TICK_DIV=1, one with TICK_DIV=4.
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en1 = 1'b1, en4 = 1'b0;
  logic        req1 = 1'b0, req4 = 1'b0;
  logic        bus_we = 1'b0;
  logic [15:0] bus_addr = 16'd0;
  logic [31:0] bus_wdata = 32'd0;

  logic        rvalid1, err1, irqt1, irqs1;
  logic [31:0] rdata1;
  logic        rvalid4, err4, irqt4, irqs4;
  logic [31:0] rdata4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint_timer #(.ADDR_WIDTH(16), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .mtime_en(en1), .bus_req(req1), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rvalid(rvalid1), .bus_rdata(rdata1),
    .bus_err(err1), .irq_timer(irqt1), .irq_software(irqs1)
  );

  clint_timer #(.ADDR_WIDTH(16), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .mtime_en(en4), .bus_req(req4), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rvalid(rvalid4), .bus_rdata(rdata4),
    .bus_err(err4), .irq_timer(irqt4), .irq_software(irqs4)
  );

  // Called at a negedge; returns at the next negedge with the response sampled.
  task automatic bus_rd(input bit four, input logic [15:0] a,
                        output logic [31:0] d, output logic v, output logic e);
    bus_we = 1'b0; bus_addr = a;
    if (four) req4 = 1'b1; else req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0; req4 = 1'b0;
    if (four) begin d = rdata4; v = rvalid4; e = err4; end
    else      begin d = rdata1; v = rvalid1; e = err1; end
  endtask

  task automatic bus_wr(input bit four, input logic [15:0] a, input logic [31:0] wd,
                        output logic v, output logic e);
    bus_we = 1'b1; bus_addr = a; bus_wdata = wd;
    if (four) req4 = 1'b1; else req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0; req4 = 1'b0; bus_we = 1'b0;
    if (four) begin v = rvalid4; e = err4; end
    else      begin v = rvalid1; e = err1; end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v, e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rvalid1, err1, irqt1, irqs1, rdata1, rvalid4, err4, irqt4, irqs4, rdata4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h %b/%h required all zero",
               {rvalid1, err1, irqt1, irqs1}, rdata1, {rvalid4, err4, irqt4, irqs4}, rdata4);
    end
    rst = 1'b0;
    bus_rd(1'b0, 16'h4004, d, v, e);
    checks++;
    if (d !== 32'hFFFF_FFFF || v !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL reset_cmp_hi: got %h v%b e%b required ffffffff v1 e0", d, v, e);
    end
    bus_rd(1'b0, 16'h0000, d, v, e);
    checks++;
    if (d !== 32'd0 || v !== 1'b1) begin
      errors++; $display("FAIL reset_msip: got %h v%b required 0 v1", d, v);
    end
  endtask

  task automatic test_count();
    logic [31:0] d; logic v, e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (irqt1 !== 1'b0) begin
        errors++; $display("FAIL count_irq_low: cycle %0d got %b required 0", i, irqt1);
      end
    end
    bus_rd(1'b0, 16'hBFF8, d, v, e);
    checks++;
    if (d !== 32'd10 || v !== 1'b1) begin
      errors++; $display("FAIL count_mtime_lo: got %0d v%b required 10 v1", d, v);
    end
  endtask

  // Entered with mtime = 11 at this negedge.
  task automatic test_compare();
    logic v, e;
    bus_wr(1'b0, 16'h4000, 32'd20, v, e);
    bus_wr(1'b0, 16'h4004, 32'd0, v, e);
    repeat (7) @(negedge clk);
    checks++;
    if (irqt1 !== 1'b0) begin
      errors++; $display("FAIL cmp_irq_at_20: got %b required 0", irqt1);
    end
    @(negedge clk);
    checks++;
    if (irqt1 !== 1'b1) begin
      errors++; $display("FAIL cmp_irq_rise: got %b required 1", irqt1);
    end
    bus_wr(1'b0, 16'h4004, 32'd1, v, e);
    checks++;
    if (irqt1 !== 1'b1) begin
      errors++; $display("FAIL cmp_irq_hold: got %b required 1", irqt1);
    end
    @(negedge clk);
    checks++;
    if (irqt1 !== 1'b0) begin
      errors++; $display("FAIL cmp_irq_clear: got %b required 0", irqt1);
    end
  endtask

  task automatic test_carry();
    logic [31:0] d; logic v, e;
    en1 = 1'b0;
    bus_wr(1'b0, 16'hBFFC, 32'd0, v, e);
    bus_wr(1'b0, 16'hBFF8, 32'hFFFF_FFFF, v, e);
    en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    bus_rd(1'b0, 16'hBFF8, d, v, e);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL carry_lo: got %h required 0", d); end
    bus_rd(1'b0, 16'hBFFC, d, v, e);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL carry_hi: got %h required 1", d); end
    bus_wr(1'b0, 16'hBFF8, 32'hFFFF_FFFF, v, e);
    en1 = 1'b1;
    bus_wr(1'b0, 16'hBFF8, 32'h0000_1234, v, e);
    en1 = 1'b0;
    bus_rd(1'b0, 16'hBFFC, d, v, e);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL carry_wr_hi: got %h required 2", d); end
    bus_rd(1'b0, 16'hBFF8, d, v, e);
    checks++;
    if (d !== 32'h1234) begin errors++; $display("FAIL carry_wr_lo: got %h required 1234", d); end
  endtask

  task automatic test_prescale();
    logic [31:0] d; logic v, e;
    en4 = 1'b1;
    repeat (6) @(negedge clk);
    en4 = 1'b0;
    bus_rd(1'b1, 16'hBFF8, d, v, e);
    checks++;
    if (d !== 32'd1 || v !== 1'b1) begin
      errors++; $display("FAIL presc_after6: got %0d v%b required 1 v1", d, v);
    end
    repeat (5) @(negedge clk);
    bus_rd(1'b1, 16'hBFF8, d, v, e);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL presc_frozen: got %0d required 1", d); end
    en4 = 1'b1;
    repeat (6) @(negedge clk);
    en4 = 1'b0;
    bus_rd(1'b1, 16'hBFF8, d, v, e);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL presc_after12: got %0d required 3", d); end
    bus_rd(1'b1, 16'hBFFC, d, v, e);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL presc_hi: got %0d required 0", d); end
  endtask

  task automatic test_msip();
    logic [31:0] d; logic v, e;
    bus_wr(1'b0, 16'h0000, 32'hFFFF_FFFF, v, e);
    checks++;
    if (irqs1 !== 1'b1 || e !== 1'b0 || v !== 1'b0) begin
      errors++; $display("FAIL msip_set: got irq%b v%b e%b required irq1 v0 e0", irqs1, v, e);
    end
    bus_rd(1'b0, 16'h0000, d, v, e);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL msip_read: got %h required 1", d); end
    bus_wr(1'b0, 16'h0000, 32'd0, v, e);
    checks++;
    if (irqs1 !== 1'b0) begin errors++; $display("FAIL msip_clear: got %b required 0", irqs1); end
  endtask

  task automatic test_error();
    logic [31:0] d; logic v, e;
    bus_rd(1'b0, 16'h0008, d, v, e);
    checks++;
    if (e !== 1'b1 || v !== 1'b1 || d !== 32'd0) begin
      errors++; $display("FAIL err_read: got e%b v%b %h required e1 v1 0", e, v, d);
    end
    @(negedge clk);
    checks++;
    if (err1 !== 1'b0 || rvalid1 !== 1'b0 || rdata1 !== 32'd0) begin
      errors++; $display("FAIL err_pulse: got e%b v%b %h required e0 v0 0", err1, rvalid1, rdata1);
    end
    bus_wr(1'b0, 16'h4002, 32'd0, v, e);
    checks++;
    if (e !== 1'b1 || v !== 1'b0) begin
      errors++; $display("FAIL err_write: got e%b v%b required e1 v0", e, v);
    end
    bus_rd(1'b0, 16'h0002, d, v, e);
    checks++;
    if (e !== 1'b1 || d !== 32'd0) begin
      errors++; $display("FAIL err_misalign_rd: got e%b %h required e1 0", e, d);
    end
    bus_rd(1'b0, 16'h4000, d, v, e);
    checks++;
    if (d !== 32'd20 || e !== 1'b0) begin
      errors++; $display("FAIL err_cmp_lo_kept: got %0d e%b required 20 e0", d, e);
    end
  endtask

  task automatic test_back_to_back();
    bus_we = 1'b0; bus_addr = 16'h4000; req1 = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'd20) begin
      errors++; $display("FAIL b2b_first: got v%b %h required v1 14", rvalid1, rdata1);
    end
    bus_addr = 16'h4004;
    @(negedge clk);
    req1 = 1'b0;
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'd1) begin
      errors++; $display("FAIL b2b_second: got v%b %h required v1 1", rvalid1, rdata1);
    end
    @(negedge clk);
    checks++;
    if (rvalid1 !== 1'b0 || rdata1 !== 32'd0) begin
      errors++; $display("FAIL b2b_idle: got v%b %h required v0 0", rvalid1, rdata1);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d; logic v, e;
    bus_we = 1'b0; bus_addr = 16'h0008; req1 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; req1 = 1'b0;
    #1;
    checks++;
    if (rvalid1 !== 1'b0 || err1 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got v%b e%b required v0 e0", rvalid1, err1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid1 !== 1'b0 || err1 !== 1'b0 || irqt1 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: got v%b e%b irq%b required 0 0 0", rvalid1, err1, irqt1);
    end
    bus_rd(1'b0, 16'h4000, d, v, e);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rst_mid_cmp: got %h required ffffffff", d);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_compare();
    test_carry();
    test_prescale();
    test_msip();
    test_error();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Machine-level core-local interruptor: owns the 64-bit mtime counter, the 64-bit mtimecmp compare register and the msip software-interrupt bit.
- Memory-mapped on the data bus.
- Drives irq_timer and irq_software into the CSR block, which samples them into mip.MTIP/MSIP.
- Single hart, machine mode only.

Parameters:
- ADDR_WIDTH, 16, byte-offset width of the CLINT window.
- TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock, asynchronous assert, active-high
- mtime_en  input  1  1 = mtime counts; 0 = frozen (debug halt)
- bus_req  input  1  access request, valid for one cycle per access
- bus_we  input  1  1 = write, 0 = read
- bus_addr  input  ADDR_WIDTH  byte offset, word aligned
- bus_wdata  input  32  write data
- bus_rvalid  output  1  read data valid, one cycle after an accepted read
- bus_rdata  output  32  read data
- bus_err  output  1  unmapped or misaligned access, one cycle after request
- irq_timer  output  1  machine timer interrupt pending
- irq_software  output  1  machine software interrupt pending

Behaviour:
- Reset: asynchronous on rst high.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - bus_rvalid=0, bus_rdata=0, bus_err=0, irq_timer=0, irq_software=0.
- Address map, 32-bit words:
  - 0x0000 MSIP: bit0 R/W, bits 31:1 read 0.
  - 0x4000 MTIMECMP[31:0]; 0x4004 MTIMECMP[63:32].
  - 0xBFF8 MTIME[31:0]; 0xBFFC MTIME[63:32].
- Handshake: every request is accepted in its cycle; no stall.
- Read: data is sampled from register values at the request edge.
  - bus_rvalid=1 and bus_rdata are valid the following cycle, for one cycle.
  - bus_rdata returns to 0 when bus_rvalid=0.
- Write: takes effect at the request edge; the new value is visible from the next cycle.
- Error: unmapped offset or addr[1:0]!=0 gives a bus_err pulse one cycle later.
  - Write is ignored; read returns bus_rdata=0 with bus_rvalid=1.
- Prescaler:
  - When mtime_en=1, the counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle the counter equals TICK_DIV-1.
  - TICK_DIV=1 gives tick every cycle while enabled.
  - When mtime_en=0, the prescaler holds its value and no tick occurs.
- mtime update:
  - next = mtime + tick, full 64-bit carry; 2^64-1 wraps to 0.
  - A simultaneous bus write to one MTIME half replaces that half of next with bus_wdata.
  - The other half keeps next, including any carry from the increment.
  - A write to MTIME does not reset the prescaler.
- mtimecmp: written per half; no side effect on mtime.
- irq_timer: registered (mtime >= mtimecmp), unsigned 64-bit, evaluated on current register values.
  - Asserts one cycle after the condition becomes true.
  - Level, not sticky: clears one cycle after software raises mtimecmp above mtime.
  - During a split-half mtimecmp update, transient assertion is permitted; software writes hi=all-ones first.
- irq_software: equals msip bit0 (registered), no additional latency.
- No internal state machine beyond the prescaler; at most one bus access per cycle.
- Reset mid-access drops the pending response: no bus_rvalid and no bus_err after rst deasserts.

Test Plan:
- Reset then idle, TICK_DIV=1, mtime_en=1, 10 cycles -> MTIME lo read returns 10 (+/-1 for sample edge, checked exactly against model); irq_timer=0 throughout.
- Write MTIMECMP lo=20, then hi=0, with mtime counting from 0 -> irq_timer rises in the cycle after mtime reaches 20; writing MTIMECMP hi=1 clears it one cycle later.
- Write MTIME lo=FFFF_FFFF, hi=0, let one tick occur -> MTIME hi reads 1 and lo reads 0.
  - Then write lo in the same cycle as a carrying tick -> hi incremented, lo = written value.
- TICK_DIV=4, mtime_en toggled low for 7 cycles mid-count -> mtime advances exactly once per 4 enabled cycles; frozen while disabled.
- Write MSIP=1 -> irq_software=1 the next cycle; read MSIP returns 1; write 0 -> irq_software=0.
- Read offset 0x0008 and write 0x4002 -> bus_err pulse one cycle later; rdata=0; no register changes.
